// File: rtl/pic_pkg.sv
// Shared constants and helpers for the PIC16F5x return-address stack.
package pic_pkg;

    localparam int OVF_WRAP    = 0;
    localparam int OVF_SAT     = 1;
    localparam int PC_W_DEFAULT = 9;

    // Pointer width; a 2-entry stack still needs one bit.
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/pic_call_stack.sv
// Parametrised CALL/RETLW return-address stack with overflow policy and sticky flags.
// Optional macro PIC_CALL_STACK_HWM_EN adds the `hwm` high-water-mark output.
module pic_call_stack
    import pic_pkg::*;
#(
    parameter int ADDR_W   = PC_W_DEFAULT,
    parameter int DEPTH    = 2,
    parameter int OVF_MODE = OVF_WRAP,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] in,
    output logic [ADDR_W-1:0] out,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              unf,
`ifdef PIC_CALL_STACK_HWM_EN
    output logic [CNT_W-1:0]  hwm,
`endif
    input  logic              clr_err
);

    localparam int PTR_W = ptr_w(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  sp, sp_inc, sp_dec, sp_nxt, wr_idx;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              wr_en, ovf_set, unf_set;

    // Explicit compare-based wrap keeps non-power-of-two depths correct.
    assign sp_inc = (sp == PTR_W'(DEPTH - 1)) ? '0 : sp + PTR_W'(1);
    assign sp_dec = (sp == '0) ? PTR_W'(DEPTH - 1) : sp - PTR_W'(1);

    assign out   = mem[sp_dec];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = sp;
        sp_nxt  = sp;
        cnt_nxt = count;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (push && pop && !empty) begin
            wr_en  = 1'b1;
            wr_idx = sp_dec;
        end else if (push) begin
            if (!full) begin
                wr_en   = 1'b1;
                sp_nxt  = sp_inc;
                cnt_nxt = count + CNT_W'(1);
            end else begin
                ovf_set = 1'b1;
                if (OVF_MODE == OVF_WRAP) begin
                    wr_en  = 1'b1;
                    sp_nxt = sp_inc;
                end
            end
        end else if (pop) begin
            if (!empty) begin
                sp_nxt  = sp_dec;
                cnt_nxt = count - CNT_W'(1);
            end else begin
                unf_set = 1'b1;
                if (OVF_MODE == OVF_WRAP) sp_nxt = sp_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) mem[wr_idx] <= in;
            sp    <= sp_nxt;
            count <= cnt_nxt;
            // A new error in the clearing cycle wins over clr_err.
            ovf   <= (ovf & ~clr_err) | ovf_set;
            unf   <= (unf & ~clr_err) | unf_set;
        end
    end

`ifdef PIC_CALL_STACK_HWM_EN
    always_ff @(posedge clk) begin
        if (rst) hwm <= '0;
        else if (count > hwm) hwm <= count;
    end
`endif

endmodule

// File: tb/tb_pic_call_stack.sv
// Bench for pic_call_stack: three configurations checked every cycle against a behavioural model.
module tb_pic_call_stack;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       push_a [3];
    logic       pop_a  [3];
    logic       clr_a  [3];
    logic [8:0] in_a   [3];

    logic [8:0] out0, out1, out2;
    logic [1:0] c0, c1;
    logic [2:0] c2;
    logic       f0, f1, f2, e0, e1, e2, ov0, ov1, ov2, un0, un1, un2;
`ifdef PIC_CALL_STACK_HWM_EN
    logic [1:0] h0, h1;
    logic [2:0] h2;
`endif

    pic_call_stack #(.ADDR_W(9), .DEPTH(2), .OVF_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .push(push_a[0]), .pop(pop_a[0]), .in(in_a[0]),
        .out(out0), .count(c0), .full(f0), .empty(e0), .ovf(ov0), .unf(un0),
`ifdef PIC_CALL_STACK_HWM_EN
        .hwm(h0),
`endif
        .clr_err(clr_a[0]));

    pic_call_stack #(.ADDR_W(9), .DEPTH(3), .OVF_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .push(push_a[1]), .pop(pop_a[1]), .in(in_a[1]),
        .out(out1), .count(c1), .full(f1), .empty(e1), .ovf(ov1), .unf(un1),
`ifdef PIC_CALL_STACK_HWM_EN
        .hwm(h1),
`endif
        .clr_err(clr_a[1]));

    pic_call_stack #(.ADDR_W(9), .DEPTH(4), .OVF_MODE(0)) dut2 (
        .clk(clk), .rst(rst), .push(push_a[2]), .pop(pop_a[2]), .in(in_a[2]),
        .out(out2), .count(c2), .full(f2), .empty(e2), .ovf(ov2), .unf(un2),
`ifdef PIC_CALL_STACK_HWM_EN
        .hwm(h2),
`endif
        .clr_err(clr_a[2]));

    int d_out [3], d_cnt [3], d_full [3], d_empty [3], d_ovf [3], d_unf [3], d_hwm [3];
    always_comb begin
        d_out[0] = int'(out0); d_out[1] = int'(out1); d_out[2] = int'(out2);
        d_cnt[0] = int'(c0);   d_cnt[1] = int'(c1);   d_cnt[2] = int'(c2);
        d_full[0] = int'(f0);  d_full[1] = int'(f1);  d_full[2] = int'(f2);
        d_empty[0] = int'(e0); d_empty[1] = int'(e1); d_empty[2] = int'(e2);
        d_ovf[0] = int'(ov0);  d_ovf[1] = int'(ov1);  d_ovf[2] = int'(ov2);
        d_unf[0] = int'(un0);  d_unf[1] = int'(un1);  d_unf[2] = int'(un2);
`ifdef PIC_CALL_STACK_HWM_EN
        d_hwm[0] = int'(h0);   d_hwm[1] = int'(h1);   d_hwm[2] = int'(h2);
`else
        d_hwm[0] = 0;          d_hwm[1] = 0;          d_hwm[2] = 0;
`endif
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: ring of DEPTH slots, plain integer modular arithmetic.
    int dep  [3] = '{2, 3, 4};
    int mode [3] = '{0, 1, 0};
    int m_mem [3][4];
    int m_sp [3], m_cnt [3], m_ovf [3], m_unf [3], m_hwm [3];

    task automatic model_step(input int k, input bit r, input bit pu, input bit po,
                              input int din, input bit cl);
        int d, top, so, su;
        d = dep[k];
        top = (m_sp[k] + d - 1) % d;
        so = 0; su = 0;
        if (r) begin
            m_sp[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; m_hwm[k] = 0;
            for (int i = 0; i < 4; i++) m_mem[k][i] = 0;
        end else begin
            if (m_cnt[k] > m_hwm[k]) m_hwm[k] = m_cnt[k];
            if (pu && po && m_cnt[k] > 0) begin
                m_mem[k][top] = din;
            end else if (pu) begin
                if (m_cnt[k] < d) begin
                    m_mem[k][m_sp[k]] = din; m_sp[k] = (m_sp[k] + 1) % d; m_cnt[k]++;
                end else begin
                    so = 1;
                    if (mode[k] == 0) begin
                        m_mem[k][m_sp[k]] = din; m_sp[k] = (m_sp[k] + 1) % d;
                    end
                end
            end else if (po) begin
                if (m_cnt[k] > 0) begin
                    m_sp[k] = (m_sp[k] + d - 1) % d; m_cnt[k]--;
                end else begin
                    su = 1;
                    if (mode[k] == 0) m_sp[k] = (m_sp[k] + d - 1) % d;
                end
            end
            if (cl) begin m_ovf[k] = 0; m_unf[k] = 0; end
            if (so) m_ovf[k] = 1;
            if (su) m_unf[k] = 1;
        end
    endtask

    bit armed = 0;
    bit cap_r;
    bit cap_pu [3], cap_po [3], cap_cl [3];
    int cap_in [3];

    always @(posedge clk) begin
        cap_r = rst;
        for (int k = 0; k < 3; k++) begin
            cap_pu[k] = push_a[k]; cap_po[k] = pop_a[k];
            cap_cl[k] = clr_a[k];  cap_in[k] = int'(in_a[k]);
        end
        #1;
        if (cap_r) armed = 1;
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                model_step(k, cap_r, cap_pu[k], cap_po[k], cap_in[k], cap_cl[k]);
                chk($sformatf("m%0d_out", k), d_out[k], m_mem[k][(m_sp[k] + dep[k] - 1) % dep[k]]);
                chk($sformatf("m%0d_count", k), d_cnt[k], m_cnt[k]);
                chk($sformatf("m%0d_full", k), d_full[k], int'(m_cnt[k] == dep[k]));
                chk($sformatf("m%0d_empty", k), d_empty[k], int'(m_cnt[k] == 0));
                chk($sformatf("m%0d_ovf", k), d_ovf[k], m_ovf[k]);
                chk($sformatf("m%0d_unf", k), d_unf[k], m_unf[k]);
`ifdef PIC_CALL_STACK_HWM_EN
                chk($sformatf("m%0d_hwm", k), d_hwm[k], m_hwm[k]);
`endif
            end
        end
    end

    // One command on instance k for one clock; returns at the following negedge.
    task automatic cyc(input int k, input bit pu, input bit po, input int din, input bit cl);
        for (int j = 0; j < 3; j++) begin
            push_a[j] = 1'b0; pop_a[j] = 1'b0; clr_a[j] = 1'b0; in_a[j] = '0;
        end
        push_a[k] = pu; pop_a[k] = po; clr_a[k] = cl; in_a[k] = 9'(din);
        @(negedge clk);
        push_a[k] = 1'b0; pop_a[k] = 1'b0; clr_a[k] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            push_a[j] = 1'b0; pop_a[j] = 1'b0; clr_a[j] = 1'b0; in_a[j] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out0", d_out[0], 0);
        chk("rst_cnt2", d_cnt[2], 0);
        chk("rst_empty1", d_empty[1], 1);

        // DEPTH=2 wrap: basic push/pop
        cyc(0, 1, 0, 'h010, 0);
        cyc(0, 1, 0, 'h020, 0);
        chk("d2_out_020", d_out[0], 'h020);
        chk("d2_cnt_2", d_cnt[0], 2);
        chk("d2_full", d_full[0], 1);
        cyc(0, 0, 1, 0, 0);
        chk("d2_pop_out_010", d_out[0], 'h010);
        chk("d2_pop_cnt_1", d_cnt[0], 1);
        cyc(0, 0, 1, 0, 0);

        // DEPTH=2 wrap: overflow overwrites the oldest entry
        cyc(0, 1, 0, 'h011, 0);
        cyc(0, 1, 0, 'h022, 0);
        cyc(0, 1, 0, 'h033, 0);
        chk("d2_ovf", d_ovf[0], 1);
        chk("d2_ovf_out_033", d_out[0], 'h033);
        cyc(0, 0, 1, 0, 0);
        chk("d2_wrap_out_022", d_out[0], 'h022);
        cyc(0, 0, 1, 0, 0);
        chk("d2_wrap_out_033", d_out[0], 'h033);
        chk("d2_wrap_cnt_0", d_cnt[0], 0);
        cyc(0, 0, 0, 0, 1);
        chk("d2_clr_ovf", d_ovf[0], 0);

        // DEPTH=3 saturate
        for (int v = 1; v <= 4; v++) cyc(1, 1, 0, v, 0);
        chk("d3_ovf", d_ovf[1], 1);
        chk("d3_out_003", d_out[1], 'h003);
        chk("d3_cnt_3", d_cnt[1], 3);
        cyc(1, 0, 0, 0, 1);
        chk("d3_clr_ovf", d_ovf[1], 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 1);
        chk("d3_unf_set_wins", d_unf[1], 1);
        chk("d3_sat_unf_out", d_out[1], 'h003);
        chk("d3_sat_unf_cnt", d_cnt[1], 0);

        // DEPTH=4 wrap: underflow, push+pop on empty, replace top
        cyc(2, 0, 1, 0, 0);
        chk("d4_unf", d_unf[2], 1);
        chk("d4_unf_cnt", d_cnt[2], 0);
        cyc(2, 1, 1, 'h1AB, 0);
        chk("d4_pp_cnt_1", d_cnt[2], 1);
        chk("d4_pp_out_1ab", d_out[2], 'h1AB);
        chk("d4_pp_unf_kept", d_unf[2], 1);
        cyc(2, 0, 1, 0, 0);
        cyc(2, 1, 0, 'h055, 0);
        cyc(2, 1, 1, 'h066, 0);
        chk("d4_replace_cnt_1", d_cnt[2], 1);
        chk("d4_replace_out_066", d_out[2], 'h066);

        // Reset wins over a simultaneous push
        rst = 1'b1;
        cyc(2, 1, 0, 'h0F0, 0);
        rst = 1'b0;
        chk("rst_push_cnt", d_cnt[2], 0);
        chk("rst_push_out", d_out[2], 0);
        chk("rst_push_unf", d_unf[2], 0);
        chk("rst_push_ovf0", d_ovf[0], 0);

        // High-water mark
        for (int i = 0; i < 3; i++) cyc(2, 1, 0, 'h100 + i, 0);
        for (int i = 0; i < 3; i++) cyc(2, 0, 1, 0, 0);
        cyc(2, 1, 0, 'h1FF, 0);
        cyc(2, 0, 0, 0, 0);
        chk("hwm_cnt_1", d_cnt[2], 1);
`ifdef PIC_CALL_STACK_HWM_EN
        chk("hwm_3", d_hwm[2], 3);
`endif
        cyc(2, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
